// File: rtl/cpu_core_pkg.sv
// Shared types for the in-order hazard scoreboard: entry layout and
// helpers that derive tag and occupancy widths from the buffer depth.
package cpu_core_pkg;
  localparam int CORE_XLEN   = 32;
  localparam int CORE_NREGS  = 32;
  localparam int CORE_RIDX_W = $clog2(CORE_NREGS);

  typedef struct packed {
    logic                   valid;
    logic                   ready;
    logic                   wen;
    logic [CORE_RIDX_W-1:0] rd;
    logic [CORE_XLEN-1:0]   data;
  } sb_entry_t;

  function automatic int tag_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/hs_match_prio.sv
// Youngest-first search for an in-flight writer of one source register.
// Scans oldest to youngest relative to the tail so the youngest hit wins.
module hs_match_prio #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 2,
  parameter int RIDX_W = 5
) (
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [DEPTH-1:0]             wen_i,
  input  logic [DEPTH-1:0][RIDX_W-1:0] rd_i,
  input  logic [TAG_W-1:0]             tail_i,
  input  logic [RIDX_W-1:0]            rs_i,
  input  logic                         used_i,
  output logic                         hit_o,
  output logic [TAG_W-1:0]             tag_o
);
  logic [TAG_W-1:0] idx;

  always_comb begin
    hit_o = 1'b0;
    tag_o = '0;
    idx   = '0;
    // k = DEPTH wraps to the tail slot itself, which is the oldest when full
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail_i - TAG_W'(k);
      if (used_i && rs_i != '0 && valid_i[idx] && wen_i[idx] && rd_i[idx] == rs_i) begin
        hit_o = 1'b1;
        tag_o = idx;
      end
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// In-order scoreboard / forwarding buffer between decode and execute.
// Entries are allocated at issue, filled by tagged results, retired from the head.
module hazard_scoreboard
  import cpu_core_pkg::*;
#(
  parameter int XLEN  = CORE_XLEN,
  parameter int NREGS = CORE_NREGS,
  parameter int DEPTH = 4,
  parameter int TAG_W = tag_w(DEPTH),
  parameter int CNT_W = cnt_w(DEPTH)
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic                     issue_wen_i,
  input  logic [$clog2(NREGS)-1:0] issue_rd_i,
  input  logic [$clog2(NREGS)-1:0] issue_rs0_i,
  input  logic [$clog2(NREGS)-1:0] issue_rs1_i,
  input  logic                     issue_rs0_used_i,
  input  logic                     issue_rs1_used_i,
  output logic [TAG_W-1:0]         issue_tag_o,
  output logic                     hazard_o,
  output logic                     rs0_fwd_o,
  output logic                     rs1_fwd_o,
  output logic [XLEN-1:0]          rs0_fwd_data_o,
  output logic [XLEN-1:0]          rs1_fwd_data_o,
  input  logic                     result_valid_i,
  input  logic [TAG_W-1:0]         result_tag_i,
  input  logic [XLEN-1:0]          result_data_i,
  input  logic                     retire_valid_i,
  output logic                     head_valid_o,
  output logic                     retire_wen_o,
  output logic [$clog2(NREGS)-1:0] retire_rd_o,
  output logic [XLEN-1:0]          retire_data_o,
  input  logic                     flush_i,
  input  logic [CNT_W-1:0]         flush_keep_i,
  output logic [CNT_W-1:0]         count_o,
  output logic                     err_o
);
  localparam int RIDX_W = $clog2(NREGS);

  sb_entry_t        entries_q [DEPTH];
  sb_entry_t        entries_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic [DEPTH-1:0]             valid_vec, wen_vec;
  logic [DEPTH-1:0][RIDX_W-1:0] rd_vec;
  logic [1:0][RIDX_W-1:0]       rs;
  logic [1:0]                   rs_used, hit, fwd, haz;
  logic [1:0][TAG_W-1:0]        hit_tag;
  logic [1:0][XLEN-1:0]         fwd_data;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entries_q[i].valid;
      wen_vec[i]   = entries_q[i].wen;
      rd_vec[i]    = entries_q[i].rd;
    end
  end

  assign rs      = {issue_rs1_i, issue_rs0_i};
  assign rs_used = {issue_rs1_used_i, issue_rs0_used_i};

  for (genvar g = 0; g < 2; g++) begin : g_src
    hs_match_prio #(.DEPTH(DEPTH), .TAG_W(TAG_W), .RIDX_W(RIDX_W)) u_match (
      .valid_i (valid_vec),
      .wen_i   (wen_vec),
      .rd_i    (rd_vec),
      .tail_i  (tail_q),
      .rs_i    (rs[g]),
      .used_i  (rs_used[g]),
      .hit_o   (hit[g]),
      .tag_o   (hit_tag[g])
    );
  end

  always_comb begin
    fwd      = '0;
    haz      = '0;
    fwd_data = '0;
    for (int s = 0; s < 2; s++) begin
      if (hit[s]) begin
        if (entries_q[hit_tag[s]].ready) begin
          fwd[s]      = 1'b1;
          fwd_data[s] = entries_q[hit_tag[s]].data;
        end else if (result_valid_i && result_tag_i == hit_tag[s]) begin
          fwd[s]      = 1'b1;
          fwd_data[s] = result_data_i;
        end else begin
          haz[s] = 1'b1;
        end
      end
    end
  end

  assign hazard_o       = |haz;
  assign rs0_fwd_o      = fwd[0];
  assign rs1_fwd_o      = fwd[1];
  assign rs0_fwd_data_o = fwd_data[0];
  assign rs1_fwd_data_o = fwd_data[1];
  assign issue_ready_o  = (count_q < CNT_W'(DEPTH)) & ~hazard_o & ~flush_i;
  assign issue_tag_o    = tail_q;
  assign count_o        = count_q;
  assign err_o          = err_q;

  // Registered ready only: a result landing this cycle retires next cycle
  assign head_valid_o  = (count_q != '0) & entries_q[head_q].ready;
  assign retire_wen_o  = head_valid_o & entries_q[head_q].wen;
  assign retire_rd_o   = head_valid_o ? entries_q[head_q].rd   : '0;
  assign retire_data_o = head_valid_o ? entries_q[head_q].data : '0;

  logic             accept, pop, wen_eff;
  logic [CNT_W-1:0] keep;
  logic [TAG_W-1:0] age;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    err_d     = err_q;
    keep      = '0;
    age       = '0;
    accept    = issue_valid_i & issue_ready_o;
    pop       = retire_valid_i & head_valid_o;
    wen_eff   = issue_wen_i & (issue_rd_i != '0);

    if (result_valid_i) begin
      if (entries_q[result_tag_i].valid && !entries_q[result_tag_i].ready) begin
        entries_d[result_tag_i].ready = 1'b1;
        entries_d[result_tag_i].data  = result_data_i;
      end else begin
        err_d = 1'b1;
      end
    end
    if (retire_valid_i && !head_valid_o) err_d = 1'b1;

    if (flush_i) begin
      keep = (flush_keep_i > count_q) ? count_q : flush_keep_i;
      // A head retiring in the flush cycle is committed, so it always survives
      if (pop && keep == '0) keep = CNT_W'(1);
      for (int i = 0; i < DEPTH; i++) begin
        age = TAG_W'(i) - head_q;
        if (CNT_W'(age) >= keep) begin
          entries_d[i].valid = 1'b0;
          entries_d[i].ready = 1'b0;
        end
      end
      tail_d  = head_q + keep[TAG_W-1:0];
      count_d = keep - CNT_W'(pop);
    end else begin
      count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
    end

    if (pop) begin
      entries_d[head_q].valid = 1'b0;
      entries_d[head_q].ready = 1'b0;
      head_d = head_q + 1'b1;
    end

    if (accept) begin
      entries_d[tail_q].valid = 1'b1;
      entries_d[tail_q].ready = ~wen_eff;
      entries_d[tail_q].wen   = wen_eff;
      entries_d[tail_q].rd    = issue_rd_i;
      entries_d[tail_q].data  = '0;
      tail_d = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: an in-order queue model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_hazard_scoreboard;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        issue_valid_i = 1'b0, issue_wen_i = 1'b0;
  logic [4:0]  issue_rd_i = '0, issue_rs0_i = '0, issue_rs1_i = '0;
  logic        issue_rs0_used_i = 1'b0, issue_rs1_used_i = 1'b0;
  logic        result_valid_i = 1'b0;
  logic [1:0]  result_tag_i = '0;
  logic [31:0] result_data_i = '0;
  logic        retire_valid_i = 1'b0, flush_i = 1'b0;
  logic [2:0]  flush_keep_i = '0;

  logic        issue_ready_o, hazard_o, rs0_fwd_o, rs1_fwd_o;
  logic [1:0]  issue_tag_o;
  logic [31:0] rs0_fwd_data_o, rs1_fwd_data_o, retire_data_o;
  logic        head_valid_o, retire_wen_o, err_o;
  logic [4:0]  retire_rd_o;
  logic [2:0]  count_o;

  hazard_scoreboard dut (
    .clock_i(clk), .reset_i(reset_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_wen_i(issue_wen_i), .issue_rd_i(issue_rd_i),
    .issue_rs0_i(issue_rs0_i), .issue_rs1_i(issue_rs1_i),
    .issue_rs0_used_i(issue_rs0_used_i), .issue_rs1_used_i(issue_rs1_used_i),
    .issue_tag_o(issue_tag_o), .hazard_o(hazard_o),
    .rs0_fwd_o(rs0_fwd_o), .rs1_fwd_o(rs1_fwd_o),
    .rs0_fwd_data_o(rs0_fwd_data_o), .rs1_fwd_data_o(rs1_fwd_data_o),
    .result_valid_i(result_valid_i), .result_tag_i(result_tag_i),
    .result_data_i(result_data_i), .retire_valid_i(retire_valid_i),
    .head_valid_o(head_valid_o), .retire_wen_o(retire_wen_o),
    .retire_rd_o(retire_rd_o), .retire_data_o(retire_data_o),
    .flush_i(flush_i), .flush_keep_i(flush_keep_i),
    .count_o(count_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    bit          wen;
    int          rd;
    bit          ready;
    logic [31:0] data;
  } ment_t;

  ment_t q[$];
  int    m_head = 0, m_tail = 0;
  bit    m_err = 0, inited = 0;
  int    nvec = 0, nmis = 0;

  bit          e_ready, e_haz, e_hv, e_rwen;
  bit    [1:0] e_fwd;
  logic [31:0] e_fd [2];
  int          e_rrd, e_tag, e_cnt;
  logic [31:0] e_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_comb();
    int rs;
    bit used;
    e_haz = 0;
    for (int s = 0; s < 2; s++) begin
      rs   = (s == 0) ? int'(issue_rs0_i) : int'(issue_rs1_i);
      used = (s == 0) ? issue_rs0_used_i : issue_rs1_used_i;
      e_fwd[s] = 0;
      e_fd[s]  = '0;
      if (used && rs != 0) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].wen && q[i].rd == rs) begin
            if (q[i].ready) begin
              e_fwd[s] = 1; e_fd[s] = q[i].data;
            end else if (result_valid_i && int'(result_tag_i) == q[i].tag) begin
              e_fwd[s] = 1; e_fd[s] = result_data_i;
            end else begin
              e_haz = 1;
            end
            break;
          end
        end
      end
    end
    e_ready = (q.size() < DEPTH) && !e_haz && !flush_i;
    e_hv    = (q.size() > 0) && q[0].ready;
    e_rwen  = e_hv && q[0].wen;
    e_rrd   = e_hv ? q[0].rd : 0;
    e_rdata = e_hv ? q[0].data : 32'h0;
    e_tag   = m_tail;
    e_cnt   = q.size();
  endtask

  task automatic model_update();
    bit hv, acc, pop, found;
    int keep;
    if (reset_i) begin
      q.delete(); m_head = 0; m_tail = 0; m_err = 0; inited = 1;
      return;
    end
    if (!inited) return;
    model_comb();
    hv  = e_hv;
    acc = issue_valid_i && e_ready;
    if (result_valid_i) begin
      found = 0;
      foreach (q[i]) if (q[i].tag == int'(result_tag_i)) begin
        found = 1;
        if (!q[i].ready) begin q[i].ready = 1; q[i].data = result_data_i; end
        else m_err = 1;
      end
      if (!found) m_err = 1;
    end
    pop = retire_valid_i && hv;
    if (retire_valid_i && !hv) m_err = 1;
    if (flush_i) begin
      keep = (int'(flush_keep_i) > q.size()) ? q.size() : int'(flush_keep_i);
      if (pop && keep == 0) keep = 1;
      while (q.size() > keep) void'(q.pop_back());
      m_tail = (m_head + keep) % DEPTH;
    end
    if (pop) begin
      void'(q.pop_front());
      m_head = (m_head + 1) % DEPTH;
    end
    if (acc) begin
      q.push_back('{tag: m_tail, wen: issue_wen_i && issue_rd_i != 0, rd: int'(issue_rd_i),
                    ready: !(issue_wen_i && issue_rd_i != 0), data: 32'h0});
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic check_all();
    if (!inited) return;
    model_comb();
    chk("issue_ready", issue_ready_o, e_ready);
    chk("issue_tag", issue_tag_o, e_tag);
    chk("hazard", hazard_o, e_haz);
    chk("rs0_fwd", rs0_fwd_o, e_fwd[0]);
    chk("rs0_fwd_data", rs0_fwd_data_o, e_fd[0]);
    chk("rs1_fwd", rs1_fwd_o, e_fwd[1]);
    chk("rs1_fwd_data", rs1_fwd_data_o, e_fd[1]);
    chk("head_valid", head_valid_o, e_hv);
    chk("retire_wen", retire_wen_o, e_rwen);
    chk("retire_rd", retire_rd_o, e_rrd);
    chk("retire_data", retire_data_o, e_rdata);
    chk("count", count_o, e_cnt);
    chk("err", err_o, m_err);
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    issue_valid_i = 0; issue_wen_i = 0; issue_rd_i = 0; issue_rs0_i = 0; issue_rs1_i = 0;
    issue_rs0_used_i = 0; issue_rs1_used_i = 0; result_valid_i = 0; result_tag_i = 0;
    result_data_i = 0; retire_valid_i = 0; flush_i = 0; flush_keep_i = 0;
  endtask

  task automatic do_reset();
    idle();
    reset_i = 1;
    step();
    reset_i = 0;
  endtask

  task automatic set_issue(input bit wen, input logic [4:0] rd, input logic [4:0] rs0,
                           input bit u0, input logic [4:0] rs1, input bit u1);
    issue_valid_i = 1; issue_wen_i = wen; issue_rd_i = rd;
    issue_rs0_i = rs0; issue_rs0_used_i = u0; issue_rs1_i = rs1; issue_rs1_used_i = u1;
  endtask

  task automatic set_result(input logic [1:0] tag, input logic [31:0] data);
    result_valid_i = 1; result_tag_i = tag; result_data_i = data;
  endtask

  initial begin
    // RAW hazard resolved by same-cycle result bypass
    do_reset();
    settle();
    chk("rst_issue_ready", issue_ready_o, 1);
    chk("rst_count", count_o, 0);
    chk("rst_tag", issue_tag_o, 0);
    chk("rst_head_valid", head_valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_fwd0", rs0_fwd_o, 0);
    set_issue(1, 5, 0, 0, 0, 0); step();
    set_issue(1, 7, 5, 1, 0, 0); settle();
    chk("raw_hazard", hazard_o, 1);
    chk("raw_ready", issue_ready_o, 0);
    set_result(0, 32'hDEADBEEF); settle();
    chk("bypass_fwd", rs0_fwd_o, 1);
    chk("bypass_data", rs0_fwd_data_o, 32'hDEADBEEF);
    chk("bypass_ready", issue_ready_o, 1);
    chk("bypass_tag", issue_tag_o, 1);
    step(); idle(); settle();
    chk("s1_count", count_o, 2);
    chk("s1_retire_rd", retire_rd_o, 5);
    chk("s1_retire_data", retire_data_o, 32'hDEADBEEF);
    retire_valid_i = 1; step(); idle(); settle();
    chk("s1_count_after", count_o, 1);

    // Youngest writer wins
    do_reset();
    set_issue(1, 3, 0, 0, 0, 0); step(); step();
    idle(); set_result(0, 32'h11); step();
    set_result(1, 32'h22); step();
    idle(); set_issue(0, 0, 0, 0, 3, 1); settle();
    chk("young_fwd", rs1_fwd_o, 1);
    chk("young_data", rs1_fwd_data_o, 32'h22);
    chk("young_hazard", hazard_o, 0);
    step(); idle();

    // Full buffer, retire frees space next cycle, tag wrap
    do_reset();
    for (int r = 1; r <= 4; r++) begin set_issue(1, 5'(r), 0, 0, 0, 0); step(); end
    idle(); settle();
    chk("full_count", count_o, 4);
    chk("full_ready", issue_ready_o, 0);
    set_result(0, 32'hA); step();
    idle(); retire_valid_i = 1; set_issue(1, 9, 0, 0, 0, 0); settle();
    chk("full_retire_ready", issue_ready_o, 0);
    step(); idle(); settle();
    chk("freed_count", count_o, 3);
    chk("freed_ready", issue_ready_o, 1);
    chk("wrap_tag", issue_tag_o, 0);
    set_issue(1, 9, 0, 0, 0, 0); step(); idle(); settle();
    chk("wrap_count", count_o, 4);
    chk("wrap_next_tag", issue_tag_o, 1);

    // Flush keeping one with same-cycle retire, then a stale result
    do_reset();
    for (int r = 1; r <= 3; r++) begin set_issue(1, 5'(r), 0, 0, 0, 0); step(); end
    idle(); set_result(0, 32'h5); step();
    idle(); flush_i = 1; flush_keep_i = 1; retire_valid_i = 1; settle();
    chk("flush_head_valid", head_valid_o, 1);
    step(); idle(); settle();
    chk("flush_count", count_o, 0);
    set_result(2, 32'h77); step(); idle(); settle();
    chk("stale_err", err_o, 1);

    // rd=0 writer is born ready and never hazards
    do_reset();
    set_issue(1, 0, 0, 1, 0, 0); settle();
    chk("r0_hazard", hazard_o, 0);
    step(); idle(); settle();
    chk("r0_head_valid", head_valid_o, 1);
    chk("r0_retire_wen", retire_wen_o, 0);
    retire_valid_i = 1; step(); idle(); settle();
    chk("r0_count", count_o, 0);

    // Retire of a not-ready head
    do_reset();
    set_issue(1, 6, 0, 0, 0, 0); step();
    idle(); retire_valid_i = 1; step(); idle(); settle();
    chk("bad_retire_count", count_o, 1);
    chk("bad_retire_err", err_o, 1);

    // Mixed traffic against the model, including a mid-run reset
    do_reset();
    for (int c = 0; c < 300; c++) begin
      idle();
      reset_i = (c == 150);
      if ($urandom_range(1, 0) == 1)
        set_issue(1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                  1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)), 1'($urandom_range(1, 0)));
      if ($urandom_range(9, 0) < 4) begin
        if (q.size() > 0 && $urandom_range(9, 0) != 0)
          set_result(2'(q[$urandom_range(q.size() - 1, 0)].tag), $urandom);
        else
          set_result(2'($urandom_range(3, 0)), $urandom);
      end
      retire_valid_i = ($urandom_range(1, 0) == 1);
      if ($urandom_range(19, 0) == 0) begin
        flush_i = 1; flush_keep_i = 3'($urandom_range(4, 0));
      end
      step();
    end
    reset_i = 0;
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised in-order scoreboard and forwarding buffer. It replaces the fixed-stage operand-forward logic between decode and execute. Every register-writing instruction gets a tagged entry at issue; the entry captures its result when produced and retires in order to the register file. Decode gets a RAW stall and per-operand forwarded data from any in-flight entry, for any pipeline depth up to DEPTH.

Parameters:
XLEN, 32, datapath width
NREGS, 32, architectural register count; register 0 hard-wired zero
DEPTH, 4, max in-flight entries; power of 2, >=2
TAG_W, $clog2(DEPTH), entry tag width (derived)
CNT_W, $clog2(DEPTH)+1, occupancy width (derived)

Ports:
clock_i  in  1  clock, rising edge
reset_i  in  1  reset, synchronous, active-high
issue_valid_i  in  1  decode presents instruction
issue_ready_o  out  1  entry free and no RAW hazard
issue_wen_i  in  1  instruction writes rd
issue_rd_i  in  $clog2(NREGS)  destination
issue_rs0_i / issue_rs1_i  in  $clog2(NREGS)  sources
issue_rs0_used_i / issue_rs1_used_i  in  1  source actually read
issue_tag_o  out  TAG_W  tag assigned on accept (= tail pointer)
hazard_o  out  1  RAW stall reason (excludes full)
rs0_fwd_o / rs1_fwd_o  out  1  use forwarded data instead of regfile
rs0_fwd_data_o / rs1_fwd_data_o  out  XLEN  forwarded value
result_valid_i  in  1  execute/mem result available
result_tag_i  in  TAG_W  entry tag of result
result_data_i  in  XLEN  result value
retire_valid_i  in  1  write-back consumes head
head_valid_o  out  1  head entry present and ready
retire_wen_o  out  1  head writes register file
retire_rd_o  out  $clog2(NREGS)  head destination
retire_data_o  out  XLEN  head result
flush_i  in  1  branch flush
flush_keep_i  in  CNT_W  oldest entries that survive flush
count_o  out  CNT_W  occupancy
err_o  out  1  sticky: illegal retire or stale-tag result

Behaviour:
- Entry fields: valid, ready, wen, rd, data. Circular buffer with head/tail pointers and count.
- Issue accept = issue_valid_i & issue_ready_o. Accept writes tail: valid=1, wen=issue_wen_i & (rd!=0), ready=~wen (non-writers are born ready), data=0. Tail increments mod DEPTH. issue_tag_o = tail, combinational.
- Source match: rsN_used, rsN!=0, equal to rd of a valid wen entry. The youngest match (nearest tail) wins.
- Match ready -> rsN_fwd_o=1, data = entry data.
- Match not ready, but result_valid_i & result_tag_i == that tag this cycle -> fwd=1, data=result_data_i (same-cycle bypass).
- Otherwise -> hazard.
- No match -> fwd=0, data=0.
- issue_ready_o = (count<DEPTH) & ~hazard_o & ~flush_i. A same-cycle retire does not free space for issue.
- Result: if the tagged entry is valid and not ready, set ready and store data. If the entry is invalid or already ready: ignore and set err_o.
- Retire: head_valid_o = count>0 & head.ready. retire_valid_i & head_valid_o pops the head; head increments and count decrements. retire_valid_i without head_valid_o: ignored, err_o set.
- Flush: valid entries beyond the oldest flush_keep_i (counted before this cycle's retire) are invalidated. tail = head + flush_keep_i; the same-cycle retire still pops. Same-cycle issue is dropped. flush_keep_i > count is clamped to count.
- Simultaneous: result and retire to the same head entry -> not retired this cycle (head_valid_o uses registered ready). Issue + retire + result in one cycle are all legal.
- Reset: all valid/ready=0, pointers and count=0, err_o=0. Outputs then: issue_ready_o=1 (combinational), hazard_o=0, fwd=0, fwd data=0, head_valid_o=0, retire_* =0, issue_tag_o=0.
- Reset mid-operation discards all entries, no retire. Pointer wrap is natural mod DEPTH.

Decomposition:
- Package cpu_core_pkg: entry struct typedef (valid, ready, wen, rd, data), TAG_W/CNT_W helper functions.
- One sub-module: hs_match_prio, a youngest-match priority search over DEPTH entries relative to the tail. Instantiated once per source operand.

Test Plan:
- Reset, then issue wen rd=5 (tag 0); next issue reads rs0=5 -> hazard_o=1, issue_ready_o=0. Result tag0 data 0xDEADBEEF that cycle -> rs0_fwd_o=1, data 0xDEADBEEF, accepted.
- Issue rd=3 twice (tags 0, 1); results 0x11 and 0x22; read rs1=3 -> forwards 0x22 (youngest).
- DEPTH=4: issue 4 writers -> count_o=4, issue_ready_o=0. Retire one (after its result) -> ready next cycle. Tags wrap 3->0.
- Three entries in flight, flush_i with flush_keep_i=1 plus same-cycle retire of ready head -> count_o=0. A late result to tag 2 -> ignored, err_o=1.
- Issue rd=0 with rs0=0 used -> no hazard, retire_wen_o=0, entry is ready immediately.
- retire_valid_i while head not ready -> no pop, count unchanged, err_o=1.
